// File: rtl/led_blink_tx_if.sv
// Word handshake between upstream status logic and the LED blink transmitter.
// The master is the word producer. The slave is the blinker.
interface led_blink_tx_if #(
   parameter int CNT_W = 4
);
   logic [CNT_W-1:0] DATA;
   logic             VALID;
   logic             READY;

   modport master (output DATA, output VALID, input READY);
   modport slave  (input DATA, input VALID, output READY);
endinterface

// File: rtl/led_blink_tx.sv
// LED blink transmitter: blinks the LED DATA times, then holds it dark for an
// inter-word gap before accepting the next word over a VALID/READY handshake.
module led_blink_tx #(
   parameter int CNT_W     = 4,
   parameter int ON_TICKS  = 3200000,
   parameter int OFF_TICKS = 3200000,
   parameter int GAP_TICKS = 12000000
) (
   input  logic         CLK,
   input  logic         RESET_N,
   led_blink_tx_if.slave bus,
   output logic         BUSY,
   output logic         DONE,
   output logic         LED
);

   localparam int MAX_A     = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int MAX_TICKS = (MAX_A > GAP_TICKS) ? MAX_A : GAP_TICKS;
   localparam int TW        = $clog2(MAX_TICKS) + 1;

   localparam logic [TW-1:0] ON_LOAD  = TW'(ON_TICKS - 1);
   localparam logic [TW-1:0] OFF_LOAD = TW'(OFF_TICKS - 1);
   localparam logic [TW-1:0] GAP_LOAD = TW'(GAP_TICKS - 1);

   typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

   state_t           state, state_n;
   logic [TW-1:0]    timer, timer_n;
   logic [CNT_W-1:0] rem, rem_n;
   logic             accept;

   assign accept = bus.VALID && bus.READY;

   // NOTE: every combinational output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      state_n = state;
      timer_n = timer;
      rem_n   = rem;
      case (state)
         IDLE: begin
            if (accept) begin
               rem_n = bus.DATA;
               if (bus.DATA != '0) begin
                  state_n = ON;
                  timer_n = ON_LOAD;
               end else begin
                  state_n = GAP;
                  timer_n = GAP_LOAD;
               end
            end
         end
         ON: begin
            if (timer == '0) begin
               // rem is at least 1 here, so the decrement never wraps.
               rem_n = rem - CNT_W'(1);
               if (rem == CNT_W'(1)) begin
                  state_n = GAP;
                  timer_n = GAP_LOAD;
               end else begin
                  state_n = OFF;
                  timer_n = OFF_LOAD;
               end
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         OFF: begin
            if (timer == '0) begin
               state_n = ON;
               timer_n = ON_LOAD;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         GAP: begin
            if (timer == '0) begin
               state_n = IDLE;
               timer_n = '0;
            end else begin
               timer_n = timer - TW'(1);
            end
         end
         default: begin
            state_n = IDLE;
            timer_n = '0;
         end
      endcase
   end

   // Outputs are registered from the next-state decode so they line up with
   // the state they describe.
   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge CLK) begin
      // NOTE: reset is synchronous; it aborts any word in flight and clears
      // every register, including the timer and remaining count.
      if (!RESET_N) begin
         state     <= IDLE;
         timer     <= '0;
         rem       <= '0;
         LED       <= 1'b0;
         DONE      <= 1'b0;
         bus.READY <= 1'b1;
         BUSY      <= 1'b0;
      end else begin
         state     <= state_n;
         timer     <= timer_n;
         rem       <= rem_n;
         LED       <= (state_n == ON);
         DONE      <= (state_n == GAP) && (timer_n == '0);
         bus.READY <= (state_n == IDLE);
         BUSY      <= (state_n != IDLE);
      end
   end

endmodule

// File: tb/tb_led_blink_tx.sv
// Directed bench for led_blink_tx with short tick counts: per-word vector
// table plus hand-written back-to-back, reset-abort and data-change sequences.
module tb_led_blink_tx;

   localparam int CNT_W = 4;
   localparam int ON_T  = 3;
   localparam int OFF_T = 2;
   localparam int GAP_T = 5;
   localparam int BOUND = 250;

   logic clk = 1'b0;
   logic rst_n;
   logic busy, done, led;

   led_blink_tx_if #(.CNT_W(CNT_W)) bus ();

   led_blink_tx #(
      .CNT_W(CNT_W), .ON_TICKS(ON_T), .OFF_TICKS(OFF_T), .GAP_TICKS(GAP_T)
   ) dut (
      .CLK(clk), .RESET_N(rst_n), .bus(bus), .BUSY(busy), .DONE(done), .LED(led)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [CNT_W-1:0] data;
      int               blinks;
      int               done_cyc;
      int               ready_cyc;
   } vec_t;

   vec_t vecs[5];
   int   n_pass = 0;
   int   n_total = 0;

   // Cycle results gathered by monitor(); cycle 1 is the cycle after the accepting edge.
   int           m_blinks, m_done_cyc, m_done_cnt, m_ready_cyc, m_width_err, m_busy_err;
   logic [255:0] m_trace;

   task automatic check(input string name, input int actual, input int expected);
      n_total++;
      if (actual == expected) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents a word and returns sampled at cycle 1 with VALID still high.
   task automatic accept(input logic [CNT_W-1:0] d);
      int n = 0;
      bus.DATA  = d;
      bus.VALID = 1'b1;
      while (!bus.READY && n < BOUND) begin
         step();
         n++;
      end
      check("ready_before_accept", int'(bus.READY), 1);
      step();
   endtask

   // Watches from the current cycle (cycle 1) until READY returns.
   task automatic monitor();
      int   c = 1;
      int   run = 0;
      logic prev = 1'b0;
      m_blinks = 0; m_done_cyc = -1; m_done_cnt = 0; m_ready_cyc = -1;
      m_width_err = 0; m_busy_err = 0; m_trace = '0;
      while (c < BOUND) begin
         if (led && !prev) m_blinks++;
         if (led) run++;
         if (!led && prev) begin
            if (run != ON_T) m_width_err++;
            run = 0;
         end
         prev = led;
         if (c < 256) m_trace[c] = led;
         if (busy == bus.READY) m_busy_err++;
         if (done) begin
            m_done_cnt++;
            if (m_done_cyc < 0) m_done_cyc = c;
         end
         if (bus.READY) begin
            m_ready_cyc = c;
            break;
         end
         step();
         c++;
      end
      if (m_ready_cyc < 0) $display("FAIL ready_timeout: got no READY, expected READY within %0d cycles", BOUND);
   endtask

   task automatic check_word(input string tag, input int blinks, input int done_cyc, input int ready_cyc);
      check({tag, "_blinks"}, m_blinks, blinks);
      check({tag, "_done_cycle"}, m_done_cyc, done_cyc);
      check({tag, "_done_pulses"}, m_done_cnt, 1);
      check({tag, "_ready_cycle"}, m_ready_cyc, ready_cyc);
      check({tag, "_width_err"}, m_width_err, 0);
      check({tag, "_busy_err"}, m_busy_err, 0);
   endtask

   function automatic int pattern3();
      int p = 0;
      for (int c = 0; c < 20; c++)
         if ((c >= 1 && c <= 3) || (c >= 6 && c <= 8) || (c >= 11 && c <= 13)) p |= (1 << c);
      return p;
   endfunction

   initial begin
      int extra_done;
      int led_seen;

      vecs[0] = '{data: 4'd3,  blinks: 3,  done_cyc: 18, ready_cyc: 19};
      vecs[1] = '{data: 4'd0,  blinks: 0,  done_cyc: 5,  ready_cyc: 6};
      vecs[2] = '{data: 4'd15, blinks: 15, done_cyc: 78, ready_cyc: 79};
      vecs[3] = '{data: 4'd1,  blinks: 1,  done_cyc: 8,  ready_cyc: 9};
      vecs[4] = '{data: 4'd2,  blinks: 2,  done_cyc: 13, ready_cyc: 14};

      rst_n = 1'b0;
      bus.VALID = 1'b0;
      bus.DATA = '0;
      repeat (3) step();
      check("rst_led", int'(led), 0);
      check("rst_ready", int'(bus.READY), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst_n = 1'b1;
      step();

      foreach (vecs[i]) begin
         accept(vecs[i].data);
         bus.VALID = 1'b0;
         check($sformatf("v%0d_ready_dropped", i), int'(bus.READY), 0);
         monitor();
         check_word($sformatf("v%0d", i), vecs[i].blinks, vecs[i].done_cyc, vecs[i].ready_cyc);
         if (vecs[i].data == 4'd3) check("v_led_pattern3", int'(m_trace[19:0]), pattern3());
      end

      // Data changes while busy must not alter the word in flight.
      accept(4'd3);
      bus.VALID = 1'b0;
      bus.DATA  = 4'hA;
      monitor();
      check("chg_led_pattern", int'(m_trace[19:0]), pattern3());
      check("chg_ready_cycle", m_ready_cyc, 19);

      // VALID held across the whole word: the second word goes in on the first READY cycle.
      accept(4'd2);
      bus.DATA = 4'd1;
      monitor();
      check("b2b_first_blinks", m_blinks, 2);
      check("b2b_first_ready", m_ready_cyc, 14);
      step();
      check("b2b_taken_immediately", int'(bus.READY), 0);
      bus.VALID = 1'b0;
      monitor();
      check_word("b2b_second", 1, 8, 9);

      // Reset during the second ON of a 3-blink word.
      accept(4'd3);
      bus.VALID = 1'b0;
      repeat (6) step();
      check("abort_in_second_on", int'(led), 1);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("abort_led", int'(led), 0);
      check("abort_ready", int'(bus.READY), 1);
      check("abort_busy", int'(busy), 0);
      extra_done = int'(done);
      led_seen = int'(led);
      for (int k = 0; k < 20; k++) begin
         step();
         extra_done += int'(done);
         led_seen += int'(led);
      end
      check("abort_no_done", extra_done, 0);
      check("abort_led_stays_low", led_seen, 0);
      accept(4'd1);
      bus.VALID = 1'b0;
      monitor();
      check_word("after_abort", 1, 8, 9);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
